alu_cmd_ctrl: RTL and testbench

- Command-side initiator for the team's n-bit 8-operation ALU (combinational responder).
- Accepts commands over a valid/ready handshake and holds an accumulator (ACC).
- Drives registered operands and opcode to an external ALU instance, captures its result and carry into ACC/flags, and returns each result over a valid/ready response channel.

---
 rtl/alu_cmd_ctrl.sv | 107 ++++++++++
 tb/tb_alu_cmd_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// ============================================================================
//  Module      : alu_cmd_ctrl
//  Description : Command-side initiator for an external combinational N-bit
//                8-operation ALU. Holds an accumulator, issues registered
//                operands/opcode and returns each result over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_load,
    input  logic [2:0]   cmd_op,
    input  logic [N-1:0] cmd_data,

    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [N-1:0] alu_o,
    input  logic         alu_co,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_carry,
    output logic         rsp_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t       state_q;
    logic [N-1:0] acc_q;
    logic [N-1:0] b_q;
    logic [2:0]   sel_q;
    logic         carry_q;
    logic         rsp_valid_q;

    // Accumulator, operand and flag updates all follow the FSM, so they share one block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            b_q         <= '0;
            sel_q       <= 3'd0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            acc_q       <= cmd_data;
                            carry_q     <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            b_q     <= cmd_data;
                            sel_q   <= cmd_op;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    acc_q       <= alu_o;
                    carry_q     <= alu_co;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Held low throughout reset so nothing is accepted while the block is cleared.
    assign cmd_ready = (state_q == S_IDLE) && !rst;

    assign alu_a     = acc_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = acc_q;
    assign rsp_carry = carry_q;
    assign rsp_zero  = (acc_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
// ============================================================================
//  Module      : tb_alu_cmd_ctrl
//  Description : Directed self-checking bench for alu_cmd_ctrl with a
//                behavioural model of the attached ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_load;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_data;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_sel;
    logic [N-1:0] alu_o;
    logic         alu_co;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_carry;
    logic         rsp_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_o     (alu_o),
        .alu_co    (alu_co),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero)
    );

    // Attached ALU: DCR and CMP act on b; CMP returns the complement of b.
    logic [N:0] alu_full;
    always_comb begin
        alu_full = '0;
        case (alu_sel)
            3'd0: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: alu_full = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: alu_full = {1'b0, alu_a} + 1'b1;
            3'd3: alu_full = {1'b0, alu_b} - 1'b1;
            3'd4: alu_full = {1'b0, alu_a & alu_b};
            3'd5: alu_full = {1'b0, alu_a | alu_b};
            3'd6: alu_full = {1'b0, alu_a ^ alu_b};
            default: alu_full = {1'b0, ~alu_b};
        endcase
    end
    assign alu_o  = alu_full[N-1:0];
    assign alu_co = alu_full[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic load, input logic [2:0] op, input logic [N-1:0] data);
        cmd_valid = 1'b1;
        cmd_load  = load;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd7;
        cmd_data  = '1;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rv_after"}, rsp_valid, 1'b0);
        chk({tag, "_rdy_after"}, cmd_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data",  rsp_data,  4'h0);
        chk("rst_rsp_zero",  rsp_zero,  1'b1);
        chk("rst_rsp_carry", rsp_carry, 1'b0);
        chk("rst_alu_b",     alu_b,     4'h0);
        chk("rst_alu_sel",   alu_sel,   3'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);

        // Load 9: response one cycle after accept
        send(1'b1, 3'd5, 4'h9);
        chk("ld9_rv",    rsp_valid, 1'b1);
        chk("ld9_data",  rsp_data,  4'h9);
        chk("ld9_carry", rsp_carry, 1'b0);
        chk("ld9_zero",  rsp_zero,  1'b0);
        chk("ld9_rdy",   cmd_ready, 1'b0);
        chk("ld9_sel_kept", alu_sel, 3'd0);
        handshake("ld9");

        // ADD 8: ISSUE cycle then response
        send(1'b0, 3'd0, 4'h8);
        chk("add_issue_rv", rsp_valid, 1'b0);
        chk("add_issue_a",  alu_a,     4'h9);
        chk("add_issue_b",  alu_b,     4'h8);
        chk("add_issue_sel", alu_sel,  3'd0);
        chk("add_issue_rdy", cmd_ready, 1'b0);
        @(negedge clk);
        chk("add_rv",    rsp_valid, 1'b1);
        chk("add_data",  rsp_data,  4'h1);
        chk("add_carry", rsp_carry, 1'b1);
        handshake("add");

        // SUB 3 from 1
        send(1'b0, 3'd1, 4'h3);
        @(negedge clk);
        chk("sub_data",  rsp_data,  4'hE);
        chk("sub_carry", rsp_carry, 1'b1);
        handshake("sub");

        // DCR of 0
        send(1'b0, 3'd3, 4'h0);
        chk("dcr_issue_sel", alu_sel, 3'd3);
        @(negedge clk);
        chk("dcr_data",  rsp_data,  4'hF);
        chk("dcr_carry", rsp_carry, 1'b1);
        handshake("dcr");

        // CMP 5
        send(1'b0, 3'd7, 4'h5);
        @(negedge clk);
        chk("cmp_data",  rsp_data,  4'hA);
        chk("cmp_carry", rsp_carry, 1'b0);
        handshake("cmp");

        // XOR 6 with A
        send(1'b0, 3'd6, 4'h6);
        @(negedge clk);
        chk("xor_data", rsp_data, 4'hC);
        handshake("xor");

        // Load C (clears carry, keeps alu_b/alu_sel), then AND 3 -> zero
        send(1'b1, 3'd2, 4'hC);
        chk("ldc_b_kept",   alu_b,   4'h6);
        chk("ldc_sel_kept", alu_sel, 3'd6);
        handshake("ldc");
        send(1'b0, 3'd4, 4'h3);
        @(negedge clk);
        chk("and_data",  rsp_data,  4'h0);
        chk("and_zero",  rsp_zero,  1'b1);
        chk("and_carry", rsp_carry, 1'b0);

        // Stall the response with a competing command pending
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_data  = 4'h7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rv",   rsp_valid, 1'b1);
            chk("stall_data", rsp_data,  4'h0);
            chk("stall_rdy",  cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        handshake("stall");
        chk("stall_no_load", rsp_data, 4'h0);

        // OR then INR wrap: F + 1 -> 0 with carry
        send(1'b0, 3'd5, 4'hF);
        @(negedge clk);
        chk("or_data", rsp_data, 4'hF);
        handshake("or");
        send(1'b0, 3'd2, 4'h0);
        @(negedge clk);
        chk("inr_wrap_data",  rsp_data,  4'h0);
        chk("inr_wrap_carry", rsp_carry, 1'b1);
        chk("inr_wrap_zero",  rsp_zero,  1'b1);
        handshake("inrw");

        // Reset during ISSUE abandons the command
        send(1'b1, 3'd0, 4'h5);
        handshake("ld5");
        send(1'b0, 3'd0, 4'h2);
        chk("pre_rst_issue_b", alu_b, 4'h2);
        rst = 1'b1;
        #1;
        chk("mid_rst_rv",   rsp_valid, 1'b0);
        chk("mid_rst_data", rsp_data,  4'h0);
        chk("mid_rst_zero", rsp_zero,  1'b1);
        chk("mid_rst_b",    alu_b,     4'h0);
        chk("mid_rst_rdy",  cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rv",   rsp_valid, 1'b0);
            chk("post_rst_data", rsp_data,  4'h0);
        end

        // Fresh INR from ACC=0
        send(1'b0, 3'd2, 4'h9);
        @(negedge clk);
        chk("inr_rv",    rsp_valid, 1'b1);
        chk("inr_data",  rsp_data,  4'h1);
        chk("inr_carry", rsp_carry, 1'b0);
        handshake("inr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
